// File: rtl/det_stream_sched.sv
// Round-robin scheduler sharing one serial 1-0-1 detector among N_CH byte requesters.
// Each granted word is shifted MSB-first into the detector and its match count is returned with the channel id.
module det_stream_sched #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1),
  parameter int ID_W   = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        req_valid,
  input  logic [N_CH*DATA_W-1:0] req_data,
  output logic [N_CH-1:0]        req_ready,
  output logic                   det_rst_n,
  output logic                   det_din,
  input  logic                   det_detected,
  output logic                   res_valid,
  output logic [ID_W-1:0]        res_ch,
  output logic [CNT_W-1:0]       res_count,
  input  logic                   res_ready,
  output logic                   busy
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DRAIN, S_RESULT} state_t;

  state_t             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    ch_q;
  logic [DATA_W-1:0]  sh_q;
  logic [BIT_W-1:0]   bit_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               hi_found, lo_found, gnt_any;
  logic [ID_W-1:0]    hi_idx, lo_idx, gnt_idx;
  logic [DATA_W-1:0]  gnt_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Lowest valid channel above the pointer wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (req_valid[c]) begin
        if (ID_W'(c) > ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(c);
        end else begin
          lo_found = 1'b1;
          lo_idx   = ID_W'(c);
        end
      end
    end
    gnt_any  = hi_found | lo_found;
    gnt_idx  = hi_found ? hi_idx : lo_idx;
    gnt_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ID_W'(c) == gnt_idx) gnt_data = req_data[c*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && gnt_any && !rst) req_ready[gnt_idx] = 1'b1;
  end

  assign det_rst_n = (state_q != S_IDLE) && (state_q != S_CLEAR) && !rst;
  assign det_din   = (state_q == S_SHIFT) & sh_q[DATA_W-1];
  assign res_valid = (state_q == S_RESULT);
  assign res_ch    = ch_q;
  assign res_count = cnt_q;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= ID_W'(N_CH - 1);
      ch_q    <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_any) begin
            sh_q    <= gnt_data;
            ch_q    <= gnt_idx;
            ptr_q   <= gnt_idx;
            cnt_q   <= '0;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          bit_q   <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          // The detector output lags one bit, so bit 0's edge has nothing to count yet.
          sh_q  <= sh_q << 1;
          bit_q <= bit_q + 1'b1;
          if (bit_q != '0 && det_detected) cnt_q <= sat_inc(cnt_q);
          if (bit_q == LAST_BIT) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (det_detected) cnt_q <= sat_inc(cnt_q);
          state_q <= S_RESULT;
        end
        S_RESULT: begin
          if (res_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/det_stream_sched.md
Name: det_stream_sched

Overview:
- Round-robin scheduler that shares one serial 1-0-1 sequence detector (`seq_det`) among N_CH byte requesters.
- Per granted byte:
  - clears the detector;
  - shifts the byte into it MSB-first, one bit per clock;
  - counts the `detected` pulses;
  - returns the match count tagged with the channel id.
- Sits between the channel request interfaces and a single `seq_det` instance.

Parameters:
- N_CH, 4: number of requesting channels (2..16).
- DATA_W, 8: bits per request word.
- CNT_W, $clog2(DATA_W+1): width of the match counter.
- ID_W, $clog2(N_CH): width of the channel id.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_CH  per-channel request valid.
- req_data  in  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- req_ready  out  N_CH  one-hot accept pulse.
- det_rst_n  out  1  drives the detector's `rst_n`.
- det_din  out  1  drives the detector's `din`.
- det_detected  in  1  from the detector's `detected` (Moore output, reflects bits consumed up to the previous edge).
- res_valid  out  1  result valid.
- res_ch  out  ID_W  channel of the result.
- res_count  out  CNT_W  number of 1-0-1 matches, overlapping allowed.
- res_ready  in  1  result consumer ready.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - state IDLE; rr pointer = N_CH-1.
  - req_ready = 0, det_rst_n = 0, det_din = 0.
  - res_valid = 0, res_ch = 0, res_count = 0, busy = 0.
- det_rst_n = 0 in IDLE and CLEAR, and during reset; 1 otherwise.
- det_din = 0 outside SHIFT.
- IDLE:
  - If any req_valid is high, grant the first valid channel searching from pointer+1 upward with wrap.
  - req_ready[g] is asserted combinationally for that cycle only.
  - At the edge: latch req_data[g] into the shift register, store g, set pointer = g, clear the counter, go to CLEAR.
  - req_ready stays 0 for all channels in every other state.
- CLEAR (1 cycle): det_rst_n = 0, go to SHIFT with bit_idx = 0.
- SHIFT (DATA_W cycles):
  - det_din = shift register MSB, shifted left at each edge.
  - At each edge with bit_idx ≥ 1, the counter increments if det_detected = 1.
  - After bit_idx = DATA_W-1, go to DRAIN.
- DRAIN (1 cycle): sample det_detected once more (the result of the last bit), then go to RESULT.
- RESULT:
  - res_valid = 1; res_ch and res_count are stable.
  - On res_valid & res_ready at an edge, go to IDLE.
  - The earliest next grant is the following cycle.
- Latency:
  - Handshake edge E0.
  - CLEAR follows E0; SHIFT spans E1..E8 (DATA_W = 8); DRAIN is the cycle after E9.
  - res_valid rises at E0 + DATA_W + 2.
- Counter saturates at 2^CNT_W-1. It cannot be reached with the default widths.
- req_valid dropping while not granted is legal and has no effect.
- Data is captured only at the grant edge.
- Reset mid-operation: all state returns to reset values immediately.
  - A pending result is discarded.
  - The detector is held in reset via det_rst_n = 0.

Test Plan:
1. Reset release, ch0 valid with 8'hA8 (1010_1000) → req_ready[0] pulses 1 cycle; det_din sequence 1,0,1,0,1,0,0,0; res_valid rises 10 edges after the grant edge with res_ch = 0, res_count = 2.
2. ch2 sends 8'hAA → res_count = 3. ch1 sends 8'h00 → res_count = 0. ch3 sends 8'h05 → res_count = 1 (match on the final bit caught in DRAIN).
3. All four channels valid continuously from reset → grant order 0,1,2,3,0; no channel is granted twice before the others are served; each req_ready is exactly one pulse per transaction.
4. res_ready held low for 20 cycles after res_valid → res_valid, res_ch and res_count stay stable; no req_ready pulses; busy = 1 throughout; one cycle after the handshake, the next grant occurs.
5. Assert rst during SHIFT bit 4 → outputs return to reset values asynchronously (before the next edge); no result is produced. After release, a fresh request completes with the correct count.
6. ch1 only, back-to-back 8'hA8 then 8'hAA → counts 2 then 3; det_rst_n is low for the CLEAR cycle between bytes, so no match leaks across the byte boundary.
